mips_regfile_2w_sb: RTL and testbench

Parametrised successor of the team's MIPS general-purpose register file, for the dual-issue datapath.
- Two asynchronous read ports and two synchronous write ports (posedge Clk).
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard, so the issue stage can detect operands still pending from multi-cycle producers (loads, MUL/DIV).
- Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).

---
 rtl/mips_regfile_pkg.sv | 11 +
 rtl/mips_reg_scoreboard.sv | 46 ++++
 rtl/mips_regfile_2w_sb.sv | 84 ++++++++
 tb/tb_mips_regfile_2w_sb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_regfile_pkg.sv
// Shared constants and types for the dual-write MIPS register file and its busy scoreboard.
package mips_regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_ADDR  = 0;

   typedef logic [DATA_W_DEF-1:0] data_t;
   typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/mips_reg_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback, wiped by a pipeline flush.
module mips_reg_scoreboard
   import mips_regfile_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Set_Busy,
   input  logic [ADDR_W-1:0] Busy_Addr,
   input  logic              W0_En,
   input  logic [ADDR_W-1:0] W0_Addr,
   input  logic              W1_En,
   input  logic [ADDR_W-1:0] W1_Addr,
   input  logic              Flush,
   input  logic [ADDR_W-1:0] R_Addr_A,
   input  logic [ADDR_W-1:0] R_Addr_B,
   output logic              Busy_A,
   output logic              Busy_B
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busyNext;

   // Set is applied after the clears because the new producer is younger than the retiring one.
   always_comb begin
      w_busyNext = r_busy;
      if (W0_En) w_busyNext[W0_Addr] = 1'b0;
      if (W1_En) w_busyNext[W1_Addr] = 1'b0;
      if (Set_Busy) w_busyNext[Busy_Addr] = 1'b1;
      if (Flush) w_busyNext = '0;
      if (ZERO_REG != 0) w_busyNext[ZERO_ADDR] = 1'b0;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_busy <= '0;
      else       r_busy <= w_busyNext;
   end

   assign Busy_A = r_busy[R_Addr_A];
   assign Busy_B = r_busy[R_Addr_B];

endmodule

// File: rtl/mips_regfile_2w_sb.sv
// Two-read/two-write MIPS register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module mips_regfile_2w_sb
   import mips_regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] R_Addr_A,
   input  logic [ADDR_W-1:0] R_Addr_B,
   output logic [DATA_W-1:0] R_Data_A,
   output logic [DATA_W-1:0] R_Data_B,
   output logic              Busy_A,
   output logic              Busy_B,
   input  logic              W0_En,
   input  logic [ADDR_W-1:0] W0_Addr,
   input  logic [DATA_W-1:0] W0_Data,
   input  logic              W1_En,
   input  logic [ADDR_W-1:0] W1_Addr,
   input  logic [DATA_W-1:0] W1_Data,
   input  logic              Set_Busy,
   input  logic [ADDR_W-1:0] Busy_Addr,
   input  logic              Flush
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic              w_w0Store;
   logic              w_w1Store;
   logic              w_zeroA;
   logic              w_zeroB;

   assign w_w0Store = W0_En && !((ZERO_REG != 0) && (W0_Addr == ADDR_W'(ZERO_ADDR)));
   assign w_w1Store = W1_En && !((ZERO_REG != 0) && (W1_Addr == ADDR_W'(ZERO_ADDR)));
   assign w_zeroA   = (ZERO_REG != 0) && (R_Addr_A == ADDR_W'(ZERO_ADDR));
   assign w_zeroB   = (ZERO_REG != 0) && (R_Addr_B == ADDR_W'(ZERO_ADDR));

   // W1 is written last so it wins a same-address collision, matching program order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      end else begin
         if (w_w0Store) r_regs[W0_Addr] <= W0_Data;
         if (w_w1Store) r_regs[W1_Addr] <= W1_Data;
      end
   end

   always_comb begin
      R_Data_A = r_regs[R_Addr_A];
      R_Data_B = r_regs[R_Addr_B];
`ifdef REGFILE_BYPASS_EN
      if (W0_En && (W0_Addr == R_Addr_A)) R_Data_A = W0_Data;
      if (W1_En && (W1_Addr == R_Addr_A)) R_Data_A = W1_Data;
      if (W0_En && (W0_Addr == R_Addr_B)) R_Data_B = W0_Data;
      if (W1_En && (W1_Addr == R_Addr_B)) R_Data_B = W1_Data;
`endif
      if (w_zeroA || Reset) R_Data_A = '0;
      if (w_zeroB || Reset) R_Data_B = '0;
   end

   mips_reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .Clk       (Clk),
      .Reset     (Reset),
      .Set_Busy  (Set_Busy),
      .Busy_Addr (Busy_Addr),
      .W0_En     (W0_En),
      .W0_Addr   (W0_Addr),
      .W1_En     (W1_En),
      .W1_Addr   (W1_Addr),
      .Flush     (Flush),
      .R_Addr_A  (R_Addr_A),
      .R_Addr_B  (R_Addr_B),
      .Busy_A    (Busy_A),
      .Busy_B    (Busy_B)
   );

endmodule

// File: tb/tb_mips_regfile_2w_sb.sv
// Directed self-checking bench for mips_regfile_2w_sb; bypass expectations follow REGFILE_BYPASS_EN.
module tb_mips_regfile_2w_sb;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [4:0]  R_Addr_A, R_Addr_B;
   logic [31:0] R_Data_A, R_Data_B;
   logic        Busy_A, Busy_B;
   logic        W0_En, W1_En, Set_Busy, Flush;
   logic [4:0]  W0_Addr, W1_Addr, Busy_Addr;
   logic [31:0] W0_Data, W1_Data;

   int checkCount = 0;
   int failCount  = 0;

   mips_regfile_2w_sb dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .R_Addr_A  (R_Addr_A),
      .R_Addr_B  (R_Addr_B),
      .R_Data_A  (R_Data_A),
      .R_Data_B  (R_Data_B),
      .Busy_A    (Busy_A),
      .Busy_B    (Busy_B),
      .W0_En     (W0_En),
      .W0_Addr   (W0_Addr),
      .W0_Data   (W0_Data),
      .W1_En     (W1_En),
      .W1_Addr   (W1_Addr),
      .W1_Data   (W1_Data),
      .Set_Busy  (Set_Busy),
      .Busy_Addr (Busy_Addr),
      .Flush     (Flush)
   );

   always #5 Clk = ~Clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic w0En, input logic [4:0] w0Addr, input logic [31:0] w0Data,
                                input logic w1En, input logic [4:0] w1Addr, input logic [31:0] w1Data,
                                input logic setB, input logic [4:0] bAddr, input logic flush);
      W0_En = w0En; W0_Addr = w0Addr; W0_Data = w0Data;
      W1_En = w1En; W1_Addr = w1Addr; W1_Data = w1Data;
      Set_Busy = setB; Busy_Addr = bAddr; Flush = flush;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic nextEdge();
      @(posedge Clk);
      #1;
   endtask

   task automatic readAt(input logic [4:0] a, input logic [4:0] b);
      R_Addr_A = a;
      R_Addr_B = b;
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      idle();
      readAt(5'd1, 5'd2);
      checkOutput("reset_data_a", R_Data_A, 32'h0);
      checkOutput("reset_busy_a", 32'(Busy_A), 32'h0);

      // Write held across an edge while in reset must be lost.
      applyStimulus(1'b1, 5'd2, 32'hCAFE_0002, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
      nextEdge();
      #2 Reset = 1'b0;
      idle();
      readAt(5'd2, 5'd2);
      checkOutput("reset_write_lost", R_Data_A, 32'h0);
      checkOutput("reset_busy_lost", 32'(Busy_A), 32'h0);

      // Fill r1..r31, two registers per cycle.
      for (int i = 1; i < 32; i += 2) begin
         applyStimulus(1'b1, 5'(i), 32'hA5A5_0000 + 32'(i),
                       (i + 1 < 32), 5'(i + 1), 32'hA5A5_0000 + 32'(i + 1),
                       1'b1, 5'(i), 1'b0);
         nextEdge();
      end
      idle();
      readAt(5'd1, 5'd31);
      checkOutput("fill_r1", R_Data_A, 32'hA5A5_0001);
      checkOutput("fill_r31", R_Data_B, 32'hA5A5_001F);
      readAt(5'd16, 5'd31);
      checkOutput("fill_r16", R_Data_A, 32'hA5A5_0010);
      checkOutput("fill_busy_r31", 32'(Busy_B), 32'h1);

      // Asynchronous reset mid-cycle clears everything immediately.
      nextEdge();
      #1 Reset = 1'b1;
      readAt(5'd1, 5'd31);
      checkOutput("async_reset_r1", R_Data_A, 32'h0);
      checkOutput("async_reset_r31", R_Data_B, 32'h0);
      checkOutput("async_reset_busy", 32'(Busy_B), 32'h0);
      #1 Reset = 1'b0;

      // Same-address collision: W1 wins.
      nextEdge();
      applyStimulus(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222, 1'b0, 5'd0, 1'b0);
      nextEdge();
      idle();
      readAt(5'd5, 5'd0);
      checkOutput("collision_w1_wins", R_Data_A, 32'h2222_2222);

      // Zero register: write ignored, busy never set.
      applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      nextEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
      nextEdge();
      idle();
      readAt(5'd0, 5'd0);
      checkOutput("zero_reg_data", R_Data_A, 32'h0);
      checkOutput("zero_reg_busy", 32'(Busy_A), 32'h0);

      // Bypass behaviour on read port B.
      applyStimulus(1'b1, 5'd7, 32'hAAAA_0007, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      nextEdge();
      applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      readAt(5'd0, 5'd7);
`ifdef REGFILE_BYPASS_EN
      checkOutput("bypass_same_cycle", R_Data_B, 32'h1234_5678);
`else
      checkOutput("nobypass_same_cycle", R_Data_B, 32'hAAAA_0007);
`endif
      nextEdge();
      idle();
      readAt(5'd0, 5'd7);
      checkOutput("write_next_cycle", R_Data_B, 32'h1234_5678);

      // Scoreboard: set, set-wins-over-clear, then clear.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
      nextEdge();
      idle();
      readAt(5'd9, 5'd0);
      checkOutput("busy_set_r9", 32'(Busy_A), 32'h1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999_0009, 1'b1, 5'd9, 1'b0);
      readAt(5'd9, 5'd0);
      checkOutput("busy_not_early_r9", 32'(Busy_A), 32'h1);
      nextEdge();
      idle();
      readAt(5'd9, 5'd0);
      checkOutput("busy_set_wins_r9", 32'(Busy_A), 32'h1);
      checkOutput("data_r9", R_Data_A, 32'h9999_0009);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999_1009, 1'b0, 5'd0, 1'b0);
      nextEdge();
      idle();
      readAt(5'd9, 5'd0);
      checkOutput("busy_clear_r9", 32'(Busy_A), 32'h0);

      // W0 also clears busy.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0);
      nextEdge();
      applyStimulus(1'b1, 5'd12, 32'hC0C0_000C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      nextEdge();
      idle();
      readAt(5'd0, 5'd12);
      checkOutput("busy_clear_w0_r12", 32'(Busy_B), 32'h0);

      // Flush: all busy cleared, overrides Set_Busy, data writes still land.
      applyStimulus(1'b1, 5'd3, 32'h3333_0003, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      nextEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
      nextEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
      nextEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
      nextEdge();
      idle();
      readAt(5'd3, 5'd6);
      checkOutput("pre_flush_busy_r3", 32'(Busy_A), 32'h1);
      checkOutput("pre_flush_busy_r6", 32'(Busy_B), 32'h1);
      applyStimulus(1'b1, 5'd11, 32'hBBBB_000B, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b1);
      nextEdge();
      idle();
      readAt(5'd3, 5'd4);
      checkOutput("flush_busy_r3", 32'(Busy_A), 32'h0);
      checkOutput("flush_busy_r4", 32'(Busy_B), 32'h0);
      checkOutput("flush_data_r3", R_Data_A, 32'h3333_0003);
      readAt(5'd6, 5'd10);
      checkOutput("flush_busy_r6", 32'(Busy_A), 32'h0);
      checkOutput("flush_busy_r10", 32'(Busy_B), 32'h0);
      readAt(5'd11, 5'd0);
      checkOutput("flush_write_r11", R_Data_A, 32'hBBBB_000B);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
